// File: rtl/eprisc_bus_master.sv
// eprisc_bus_master: host-side master for the epRISC parallel system bus.
// Serialises a WORD_W host word into LANES-wide beats (MSB first) on oBusMOSI while
// shifting iBusMISO into a receive register. It also generates a divided bus clock and
// drives one-hot active-low device selects. A select can be held across words for bursts.
// Changing the target device while a select is held inserts a deselect gap first.
//
// Optional build macro: BUS_IRQ_LATCH_EN. When it is defined, oHostIrq is a sticky flag
// set by a synchronised rising edge of iBusInterrupt. When it is undefined, oHostIrq is
// a direct pass-through of iBusInterrupt.
//
// Ports:
//   iBoardClock, iBoardReset            system clock, async active-low reset
//   iHostStart/Device/Hold/Data         transfer request, latched on accept
//   iHostIrqClear                       clears sticky IRQ (latch build only)
//   oHostBusy, oHostDone, oHostData     transfer status and received word
//   oHostIrq                            interrupt to host
//   oBusClock, oBusSelect               bus clock (idles low), active-low selects
//   oBusMOSI, iBusMISO, iBusInterrupt   bus data lanes and device interrupt
module eprisc_bus_master #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned DEVICES = 2,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                                       iBoardClock,
  input  logic                                       iBoardReset,
  input  logic                                       iHostStart,
  input  logic [(DEVICES > 1 ? $clog2(DEVICES) : 1)-1:0] iHostDevice,
  input  logic                                       iHostHold,
  input  logic [WORD_W-1:0]                          iHostData,
  input  logic                                       iHostIrqClear,
  output logic                                       oHostBusy,
  output logic                                       oHostDone,
  output logic [WORD_W-1:0]                          oHostData,
  output logic                                       oHostIrq,
  output logic                                       oBusClock,
  output logic [DEVICES-1:0]                         oBusSelect,
  output logic [LANES-1:0]                           oBusMOSI,
  input  logic [LANES-1:0]                           iBusMISO,
  input  logic                                       iBusInterrupt
);

  localparam int unsigned BEATS  = WORD_W / LANES;
  localparam int unsigned D      = (CLK_DIV == 0) ? 1 : CLK_DIV;
  localparam int unsigned DIV_W  = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEV_W  = (DEVICES > 1) ? $clog2(DEVICES) : 1;

  typedef enum logic [2:0] {StIdle, StGap, StSetup, StHigh, StLow, StDone} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [DEV_W-1:0]    dev_q;
  logic                hold_q;
  logic                held_q;   // select still asserted in IDLE after a held word
  logic [WORD_W-1:0]   tx_q, rx_q, host_data_q;
  logic                div_last, beat_last, accept, sel_en;

  assign div_last  = (div_q == DIV_W'(D - 1));
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));
  assign accept    = (state_q == StIdle) && iHostStart;

  // State register
  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) state_q <= StIdle;
    else              state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (iHostStart) state_d = (held_q && (iHostDevice != dev_q)) ? StGap : StSetup;
      end
      StGap:   if (div_last) state_d = StSetup;
      StSetup: if (div_last) state_d = StHigh;
      StHigh:  if (div_last) state_d = StLow;
      StLow:   if (div_last) state_d = beat_last ? StDone : StHigh;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: divider, beat counter, shift registers, latched request
  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      div_q       <= '0;
      beat_q      <= '0;
      dev_q       <= '0;
      hold_q      <= 1'b0;
      held_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      host_data_q <= '0;
    end else begin
      if (state_d != state_q || state_q == StIdle || state_q == StDone) div_q <= '0;
      else                                                              div_q <= div_q + 1'b1;

      if (accept) begin
        dev_q  <= iHostDevice;
        hold_q <= iHostHold;
        tx_q   <= iHostData;
        held_q <= 1'b0;
        beat_q <= '0;
      end else begin
        if (state_q == StLow && div_last) beat_q <= beat_q + 1'b1;
        // Advance to the next beat on the HIGH->LOW edge so MOSI only moves while clock is low
        if (state_q == StHigh && div_last && !beat_last) tx_q <= tx_q << LANES;
        if (state_q == StDone) held_q <= hold_q;
      end

      if (state_q == StHigh && div_q == '0) rx_q <= (rx_q << LANES) | WORD_W'(iBusMISO);
      if (state_q == StLow && div_last && beat_last) host_data_q <= rx_q;
    end
  end

  // Outputs
  always_comb begin
    oHostBusy  = (state_q == StGap) || (state_q == StSetup) ||
                 (state_q == StHigh) || (state_q == StLow);
    oHostDone  = (state_q == StDone);
    oBusClock  = (state_q == StHigh);
    oHostData  = host_data_q;
    sel_en     = 1'b0;
    oBusMOSI   = '0;
    oBusSelect = '1;
    unique case (state_q)
      StIdle:                  sel_en = held_q;
      StSetup, StHigh, StLow:  begin
        sel_en   = 1'b1;
        oBusMOSI = tx_q[WORD_W-1 -: LANES];
      end
      StDone:                  sel_en = hold_q;
      default:                 sel_en = 1'b0;
    endcase
    // Out-of-range device index matches no line, so all selects stay high
    for (int i = 0; i < int'(DEVICES); i++) begin
      if (sel_en && dev_q == DEV_W'(i)) oBusSelect[i] = 1'b0;
    end
  end

`ifdef BUS_IRQ_LATCH_EN
  logic sync1_q, sync2_q, sync3_q, irq_q;

  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= iBusInterrupt;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      // A new edge beats a simultaneous clear
      if (sync2_q && !sync3_q) irq_q <= 1'b1;
      else if (iHostIrqClear)  irq_q <= 1'b0;
    end
  end

  assign oHostIrq = irq_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = iHostIrqClear;
  assign oHostIrq         = iBusInterrupt;
`endif

endmodule

// File: tb/tb_eprisc_bus_master.sv
module tb_eprisc_bus_master;

  logic        iBoardClock = 1'b0;
  logic        iBoardReset;
  logic        iHostStart;
  logic [0:0]  iHostDevice;
  logic        iHostHold;
  logic [31:0] iHostData;
  logic        iHostIrqClear;
  logic        oHostBusy;
  logic        oHostDone;
  logic [31:0] oHostData;
  logic        oHostIrq;
  logic        oBusClock;
  logic [1:0]  oBusSelect;
  logic [7:0]  oBusMOSI;
  logic [7:0]  iBusMISO;
  logic        iBusInterrupt;

  eprisc_bus_master #(
    .LANES   (8),
    .WORD_W  (32),
    .DEVICES (2),
    .CLK_DIV (4)
  ) dut (
    .iBoardClock   (iBoardClock),
    .iBoardReset   (iBoardReset),
    .iHostStart    (iHostStart),
    .iHostDevice   (iHostDevice),
    .iHostHold     (iHostHold),
    .iHostData     (iHostData),
    .iHostIrqClear (iHostIrqClear),
    .oHostBusy     (oHostBusy),
    .oHostDone     (oHostDone),
    .oHostData     (oHostData),
    .oHostIrq      (oHostIrq),
    .oBusClock     (oBusClock),
    .oBusSelect    (oBusSelect),
    .oBusMOSI      (oBusMOSI),
    .iBusMISO      (iBusMISO),
    .iBusInterrupt (iBusInterrupt)
  );

  always #5 iBoardClock = ~iBoardClock;

  int cyc = 0;
  always @(posedge iBoardClock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mosi_exp[$];
  logic [31:0] data_exp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word transfer. Latency counts the accept cycle as cycle 0.
  task automatic run_word(input logic dev, input logic hold, input logic [31:0] data,
                          input logic [31:0] rx, input logic [1:0] exp_sel,
                          input int exp_gap, input logic [1:0] exp_done_sel, input bit poke);
    int   t0, beat, gap;
    logic prev;
    bit   got, poked;
    logic [7:0]  eb;
    logic [31:0] ed;
    @(negedge iBoardClock);
    for (int i = 0; i < 100 && oHostBusy; i++) @(negedge iBoardClock);
    iHostStart  = 1'b1;
    iHostDevice = dev;
    iHostHold   = hold;
    iHostData   = data;
    iBusMISO    = rx[31:24];
    for (int b = 0; b < 4; b++) mosi_exp.push_back(data[31-8*b -: 8]);
    data_exp.push_back(rx);
    t0 = cyc + 1;
    beat = 0; gap = 0; prev = 1'b0; got = 1'b0; poked = 1'b0;
    @(negedge iBoardClock);
    for (int i = 0; i < 400; i++) begin
      iHostStart = 1'b0;
      if (oHostBusy && oBusSelect == 2'b11) gap++;
      if (oBusClock && !prev) begin
        eb = (mosi_exp.size() != 0) ? mosi_exp.pop_front() : 8'hxx;
        check("mosi_beat", {24'd0, oBusMOSI}, {24'd0, eb});
        check("select_active", {30'd0, oBusSelect}, {30'd0, exp_sel});
      end
      if (!oBusClock && prev) begin
        beat++;
        if (beat < 4) iBusMISO = rx[31-8*beat -: 8];
        if (poke && beat == 2 && !poked) begin
          iHostStart = 1'b1;
          iHostData  = 32'hDEAD_BEEF;
          poked      = 1'b1;
        end
      end
      if (oHostDone) begin
        ed = (data_exp.size() != 0) ? data_exp.pop_front() : 32'hxxxx_xxxx;
        check("done_latency", cyc - t0 + 1, 37 + exp_gap);
        check("host_data", oHostData, ed);
        check("done_busy", {31'd0, oHostBusy}, 32'd0);
        check("done_select", {30'd0, oBusSelect}, {30'd0, exp_done_sel});
        got = 1'b1;
        break;
      end
      prev = oBusClock;
      @(negedge iBoardClock);
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    check("gap_cycles", gap, exp_gap);
  endtask

  initial begin
    iBoardReset   = 1'b0;
    iHostStart    = 1'b0;
    iHostDevice   = 1'b0;
    iHostHold     = 1'b0;
    iHostData     = '0;
    iHostIrqClear = 1'b0;
    iBusMISO      = '0;
    iBusInterrupt = 1'b0;
    repeat (3) @(negedge iBoardClock);
    check("rst_clock", {31'd0, oBusClock}, 32'd0);
    check("rst_select", {30'd0, oBusSelect}, 32'd3);
    check("rst_busy", {31'd0, oHostBusy}, 32'd0);
    check("rst_data", oHostData, 32'd0);
    check("rst_mosi", {24'd0, oBusMOSI}, 32'd0);
    iBoardReset = 1'b1;

    // Plain word on device 0
    run_word(1'b0, 1'b0, 32'hA1B2C3D4, 32'h11223344, 2'b10, 0, 2'b11, 1'b0);
    // Hold burst on device 0: select stays low between words
    run_word(1'b0, 1'b1, 32'h0102_0304, 32'h5566_7788, 2'b10, 0, 2'b10, 1'b0);
    repeat (3) @(negedge iBoardClock);
    check("held_idle_select", {30'd0, oBusSelect}, 32'd2);
    run_word(1'b0, 1'b0, 32'hF0E1_D2C3, 32'h99AA_BBCC, 2'b10, 0, 2'b11, 1'b0);
    @(negedge iBoardClock);
    check("burst_end_select", {30'd0, oBusSelect}, 32'd3);
    // Device switch after a held word: deselect gap first
    run_word(1'b0, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 2'b10, 0, 2'b10, 1'b0);
    run_word(1'b1, 1'b0, 32'h8765_4321, 32'h0BAD_1DEA, 2'b01, 4, 2'b11, 1'b0);
    // Start during beat 2 is ignored
    run_word(1'b1, 1'b0, 32'h5A5A_A5A5, 32'h0F1E_2D3C, 2'b01, 0, 2'b11, 1'b1);
    repeat (3) @(negedge iBoardClock);
    check("poke_ignored_busy", {31'd0, oHostBusy}, 32'd0);

    // Reset in the middle of a HIGH phase
    iHostStart  = 1'b1;
    iHostDevice = 1'b0;
    iHostHold   = 1'b1;
    iHostData   = 32'h7777_7777;
    @(negedge iBoardClock);
    iHostStart = 1'b0;
    for (int i = 0; i < 100 && !oBusClock; i++) @(negedge iBoardClock);
    check("reach_high", {31'd0, oBusClock}, 32'd1);
    iBoardReset = 1'b0;
    #1;
    check("mid_rst_clock", {31'd0, oBusClock}, 32'd0);
    check("mid_rst_select", {30'd0, oBusSelect}, 32'd3);
    check("mid_rst_busy", {31'd0, oHostBusy}, 32'd0);
    begin
      int dones = 0;
      repeat (4) begin
        @(negedge iBoardClock);
        if (oHostDone) dones++;
      end
      iBoardReset = 1'b1;
      repeat (45) begin
        @(negedge iBoardClock);
        if (oHostDone) dones++;
      end
      check("rst_no_done", dones, 0);
    end
    check("rst_idle_select", {30'd0, oBusSelect}, 32'd3);
    run_word(1'b1, 1'b0, 32'hC001_D00D, 32'h2468_ACE0, 2'b01, 0, 2'b11, 1'b0);

`ifdef BUS_IRQ_LATCH_EN
    @(negedge iBoardClock);
    iBusInterrupt = 1'b1;
    @(negedge iBoardClock);
    iBusInterrupt = 1'b0;
    check("irq_c1", {31'd0, oHostIrq}, 32'd0);
    @(negedge iBoardClock);
    check("irq_c2", {31'd0, oHostIrq}, 32'd0);
    @(negedge iBoardClock);
    check("irq_c3", {31'd0, oHostIrq}, 32'd1);
    repeat (5) @(negedge iBoardClock);
    check("irq_sticky", {31'd0, oHostIrq}, 32'd1);
    iHostIrqClear = 1'b1;
    @(negedge iBoardClock);
    check("irq_cleared", {31'd0, oHostIrq}, 32'd0);
    // Clear held high; the edge lands on a clear cycle and must still set
    iBusInterrupt = 1'b1;
    @(negedge iBoardClock);
    iBusInterrupt = 1'b0;
    @(negedge iBoardClock);
    @(negedge iBoardClock);
    check("irq_set_wins", {31'd0, oHostIrq}, 32'd1);
    @(negedge iBoardClock);
    check("irq_clear_after", {31'd0, oHostIrq}, 32'd0);
    iHostIrqClear = 1'b0;
`else
    iHostIrqClear = 1'b1;
    iBusInterrupt = 1'b1;
    #1;
    check("irq_follow_hi", {31'd0, oHostIrq}, 32'd1);
    @(negedge iBoardClock);
    iBusInterrupt = 1'b0;
    #1;
    check("irq_follow_lo", {31'd0, oHostIrq}, 32'd0);
    iHostIrqClear = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
